// File: rtl/keypad_event_queue.sv
// Keypad front end: column scan, per-key debounce, press/release/repeat event
// generation and an event FIFO drained through a valid/ack handshake.
module keypad_event_queue #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE     = 3,
  parameter int DEPTH        = 8,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 8,
  localparam int KEYS        = ROWS * COLS,
  localparam int KW          = (KEYS > 1) ? $clog2(KEYS) : 1,
  localparam int EW          = KW + 2
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [ROWS-1:0] H,
  output logic [COLS-1:0] V,
  output logic            out_valid,
  output logic [EW-1:0]   out_evt,
  input  logic            ack,
  output logic            overflow,
  input  logic            clr_ovf,
  output logic [1:0]      emit_state_o
);

  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW   = $clog2(SCAN_DIV);
  localparam int DW   = $clog2(DEBOUNCE + 1);
  localparam int AW   = $clog2(DEPTH);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE - 1);
  localparam logic [SW-1:0] DIV_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [KW-1:0] KEY_LAST = KW'(KEYS - 1);

  localparam logic [1:0] E_IDLE = 2'd0;
  localparam logic [1:0] E_WALK = 2'd1;
  localparam logic [1:0] E_REP  = 2'd2;

  // Valid/ready contract on the consumer side: out_valid stays high while the
  // FIFO holds an event, out_evt is stable until the cycle in which ack is
  // seen with out_valid high, and ack without out_valid has no effect.

  // ---------------- column scanner ----------------
  logic            active_q;
  logic [CW-1:0]   col_q, col_d;
  logic [SW-1:0]   div_q, div_d;
  logic            frame_q;
  logic            sample;
  logic [KEYS-1:0] raw_q, raw_d;

  assign sample = active_q && (div_q == DIV_LAST);

  always_comb begin
    col_d = col_q;
    div_d = div_q;
    if (active_q) begin
      if (sample) begin
        div_d = '0;
        col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_comb begin
    V = '0;
    for (int c = 0; c < COLS; c++) begin
      V[c] = active_q && (col_q == CW'(c));
    end
  end

  always_comb begin
    raw_d = raw_q;
    if (sample) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (col_q == CW'(c)) raw_d[r*COLS+c] = H[r];
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      active_q <= 1'b0;
      col_q    <= '0;
      div_q    <= '0;
      frame_q  <= 1'b0;
      raw_q    <= '0;
    end else begin
      active_q <= 1'b1;
      col_q    <= col_d;
      div_q    <= div_d;
      frame_q  <= sample && (col_q == COL_LAST);
      raw_q    <= raw_d;
    end
  end

  // ---------------- per-key debounce ----------------
  logic [KEYS-1:0] db_q, db_d;
  logic [KEYS-1:0] chg_q, chg_d;
  logic [KEYS-1:0] flip;
  logic [DW-1:0]   cnt_q [KEYS];
  logic [DW-1:0]   cnt_d [KEYS];

  always_comb begin
    db_d  = db_q;
    chg_d = chg_q;
    flip  = '0;
    for (int k = 0; k < KEYS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (frame_q) begin
        chg_d[k] = 1'b0;
        if (raw_q[k] == db_q[k]) begin
          cnt_d[k] = '0;
        end else if (cnt_q[k] == DB_LAST) begin
          flip[k]  = 1'b1;
          db_d[k]  = ~db_q[k];
          cnt_d[k] = '0;
          chg_d[k] = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      db_q  <= '0;
      chg_q <= '0;
      for (int k = 0; k < KEYS; k++) cnt_q[k] <= '0;
    end else begin
      db_q  <= db_d;
      chg_q <= chg_d;
      for (int k = 0; k < KEYS; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  // ---------------- event emitter ----------------
  logic [1:0]    est_q, est_d;
  logic [KW-1:0] idx_q, idx_d;
  logic          push;
  logic [EW-1:0] push_evt;
  logic          rep_take;
  logic          rep_pend;
  logic [KW-1:0] rep_code;

  // One walk per frame; the extra E_REP slot keeps repeats after the walk.
  always_comb begin
    est_d    = est_q;
    idx_d    = idx_q;
    push     = 1'b0;
    push_evt = '0;
    rep_take = 1'b0;
    case (est_q)
      E_IDLE: begin
        if (frame_q) begin
          est_d = E_WALK;
          idx_d = '0;
        end
      end
      E_WALK: begin
        if (chg_q[idx_q]) begin
          push     = 1'b1;
          push_evt = {~db_q[idx_q], 1'b0, idx_q};
        end
        if (idx_q == KEY_LAST) est_d = E_REP;
        else                   idx_d = idx_q + 1'b1;
      end
      E_REP: begin
        rep_take = 1'b1;
        if (rep_pend) begin
          push     = 1'b1;
          push_evt = {2'b01, rep_code};
        end
        est_d = E_IDLE;
      end
      default: est_d = E_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      est_q <= E_IDLE;
      idx_q <= '0;
    end else begin
      est_q <= est_d;
      idx_q <= idx_d;
    end
  end

  assign emit_state_o = est_q;

  // ---------------- auto-repeat ----------------
  if (REPEAT_EN != 0) begin : g_rep
    logic          act_q;
    logic          pend_q;
    logic [KW-1:0] key_q;
    logic [RW-1:0] rcnt_q;
    logic [KW-1:0] hi;
    logic          any_press;

    // Highest code newly pressed this frame becomes the repeat candidate.
    always_comb begin
      hi        = '0;
      any_press = 1'b0;
      for (int k = 0; k < KEYS; k++) begin
        if (flip[k] && !db_q[k]) begin
          hi        = KW'(k);
          any_press = 1'b1;
        end
      end
    end

    always_ff @(posedge Clock) begin
      if (!Reset) begin
        act_q  <= 1'b0;
        pend_q <= 1'b0;
        key_q  <= '0;
        rcnt_q <= '0;
      end else begin
        if (rep_take) pend_q <= 1'b0;
        if (frame_q) begin
          if (any_press) begin
            act_q  <= 1'b1;
            key_q  <= hi;
            rcnt_q <= RW'(REPEAT_DELAY);
          end else if (act_q && flip[key_q]) begin
            act_q <= 1'b0;
          end else if (act_q) begin
            if (rcnt_q == RW'(1)) begin
              pend_q <= 1'b1;
              rcnt_q <= RW'(REPEAT_RATE);
            end else begin
              rcnt_q <= rcnt_q - 1'b1;
            end
          end
        end
      end
    end

    assign rep_pend = pend_q;
    assign rep_code = key_q;
  end else begin : g_norep
    logic unused_rep;
    assign unused_rep = ^{rep_take, flip};
    assign rep_pend   = 1'b0;
    assign rep_code   = '0;
  end

  // ---------------- event FIFO ----------------
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   fcnt_q;
  logic          ovf_q;
  logic          full, pop, wr_en, drop;

  assign full      = (fcnt_q == (AW+1)'(DEPTH));
  assign out_valid = (fcnt_q != '0);
  assign pop       = out_valid && ack;
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign out_evt   = out_valid ? mem_q[rd_q] : '0;
  assign overflow  = ovf_q;

  always_ff @(posedge Clock) begin
    if (wr_en) mem_q[wr_q] <= push_evt;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
      // A drop in the same cycle as clr_ovf wins so no loss goes unreported.
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_event_queue.sv
// Bench for keypad_event_queue: a switch-matrix model drives H from V and a
// frame-level reference model predicts every event the consumer should see.
module tb_keypad_event_queue;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int KEYS  = ROWS * COLS;
  localparam int EW    = 6;
  localparam int SD    = 20;
  localparam int DB    = 3;
  localparam int DEPTH = 2;
  localparam int RD    = 4;
  localparam int RR    = 2;

  logic            Clock = 1'b0;
  logic            Reset = 1'b0;
  logic [ROWS-1:0] H;
  logic [COLS-1:0] V;
  logic            out_valid;
  logic [EW-1:0]   out_evt;
  logic            ack = 1'b0;
  logic            overflow;
  logic            clr_ovf = 1'b0;
  logic [1:0]      unused_emit_state;
  logic [KEYS-1:0] keys = '0;

  keypad_event_queue #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE(DB), .DEPTH(DEPTH),
    .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .Clock(Clock), .Reset(Reset), .H(H), .V(V),
    .out_valid(out_valid), .out_evt(out_evt), .ack(ack),
    .overflow(overflow), .clr_ovf(clr_ovf), .emit_state_o(unused_emit_state)
  );

  // ---- clock / reset ----
  always #5 Clock = ~Clock;

  // Switch matrix: a row senses 1 when any closed key in it sits on the driven column.
  always_comb begin
    for (int r = 0; r < ROWS; r++) H[r] = |(keys[r*COLS +: COLS] & V);
  end

  // ---- scoreboard and reference model ----
  int            errors = 0;
  int            checks = 0;
  int            ev_cnt = 0;
  int            rep_seen = 0;
  logic [EW-1:0] exp_q[$];
  bit            drain_en = 1'b1;
  bit            exp_ovf = 1'b0;
  bit            db_m [KEYS];
  int            cnt_m [KEYS];
  bit            rep_act;
  int            rep_key;
  int            held;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input bit rel, input bit rpt, input int code);
    return {rel, rpt, 4'(code)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < KEYS; k++) begin
      db_m[k]  = 1'b0;
      cnt_m[k] = 0;
    end
    rep_act = 1'b0;
    rep_key = 0;
    held    = 0;
    exp_ovf = 1'b0;
    exp_q.delete();
  endtask

  // While the consumer is stalled the FIFO keeps only the first DEPTH events.
  task automatic model_push(input logic [EW-1:0] ev);
    if (drain_en || exp_q.size() < DEPTH) exp_q.push_back(ev);
    else exp_ovf = 1'b1;
  endtask

  task automatic model_frame(input logic [KEYS-1:0] raw);
    int newp;
    bit rel;
    newp = -1;
    rel  = 1'b0;
    for (int k = 0; k < KEYS; k++) begin
      if (raw[k] == db_m[k]) begin
        cnt_m[k] = 0;
      end else begin
        cnt_m[k]++;
        if (cnt_m[k] == DB) begin
          db_m[k]  = raw[k];
          cnt_m[k] = 0;
          model_push(mk(!raw[k], 1'b0, k));
          if (raw[k]) newp = k;
          else if (rep_act && rep_key == k) rel = 1'b1;
        end
      end
    end
    if (newp >= 0) begin
      rep_act = 1'b1;
      rep_key = newp;
      held    = 0;
    end else if (rel) begin
      rep_act = 1'b0;
    end else if (rep_act) begin
      held++;
      if (held >= RD && (held - RD) % RR == 0) model_push(mk(1'b0, 1'b1, rep_key));
    end
  endtask

  // ---- driver: present one raw frame, consume events, account the frame ----
  task automatic frame(input logic [KEYS-1:0] k);
    logic [COLS-1:0] prev;
    bit              done;
    int              n;
    keys = k;
    prev = V;
    done = 1'b0;
    n    = 0;
    while (!done && n < 200) begin
      @(negedge Clock);
      n++;
      if (clr_ovf) begin
        clr_ovf = 1'b0;
        exp_ovf = 1'b0;
      end
      if (drain_en) begin
        if (out_valid) begin
          check("evt_present", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            check("evt_value", 32'(out_evt), 32'(exp_q[0]));
            void'(exp_q.pop_front());
          end
          if (out_evt[4]) rep_seen++;
          ev_cnt++;
          ack = 1'b1;
        end else begin
          check("idle_evt_zero", 32'(out_evt), 32'd0);
          ack = 1'b0;
        end
      end else begin
        ack = 1'b0;
      end
      if (prev == 4'b1000 && V == 4'b0001) done = 1'b1;
      prev = V;
    end
    check("frame_done", 32'(done), 32'd1);
    if (done) begin
      check("overflow", 32'(overflow), 32'(exp_ovf));
      if (drain_en) begin
        check("drained", 32'(exp_q.size()), 32'd0);
        check("valid_after_drain", 32'(out_valid), 32'd0);
      end
      model_frame(k);
    end
  endtask

  // ---- directed and random sequence ----
  logic [KEYS-1:0] kr;

  initial begin
    model_reset();
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_V", 32'(V), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_evt", 32'(out_evt), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    Reset = 1'b1;
    @(negedge Clock);
    check("first_V", 32'(V), 32'd1);

    // Key (row1,col2) = code 6: one press after three agreeing frames.
    frame('0);
    ev_cnt = 0;
    repeat (4) frame(16'h0040);
    check("key6_press_cnt", 32'(ev_cnt), 32'd1);
    // Release, then a two-frame bounce that must not produce anything.
    repeat (4) frame('0);
    check("key6_release_cnt", 32'(ev_cnt), 32'd2);
    frame(16'h0040);
    frame(16'h0040);
    repeat (3) frame('0);
    check("bounce_no_evt", 32'(ev_cnt), 32'd2);

    // Codes 3 and 12 closing together: queued in ascending code order.
    ev_cnt = 0;
    repeat (4) frame(16'h1008);
    check("pair_press_cnt", 32'(ev_cnt), 32'd2);
    repeat (4) frame('0);

    // Stalled consumer: three simultaneous presses into a two-entry FIFO.
    drain_en = 1'b0;
    repeat (4) frame(16'h0206);
    check("ovf_valid", 32'(out_valid), 32'd1);
    check("ovf_head", 32'(out_evt), 32'(mk(1'b0, 1'b0, 1)));
    clr_ovf = 1'b1;
    frame(16'h0206);
    check("clr_valid", 32'(out_valid), 32'd1);
    check("clr_head", 32'(out_evt), 32'(exp_q[0]));
    drain_en = 1'b1;
    repeat (5) frame('0);

    // Auto-repeat on code 5: press, repeats at +4 then every 2 frames, release.
    ev_cnt   = 0;
    rep_seen = 0;
    repeat (12) frame(16'h0020);
    repeat (6) frame('0);
    check("rep_total_evts", 32'(ev_cnt), 32'd6);
    check("rep_count", 32'(rep_seen), 32'd4);

    // Random key activity, one possible toggle per frame.
    kr = '0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) kr[$urandom_range(0, KEYS-1)] ^= 1'b1;
      frame(kr);
    end
    repeat (5) frame('0);

    // Reset while the emitter is walking with events already queued.
    drain_en = 1'b0;
    repeat (3) frame(16'h8001);
    repeat (3) @(negedge Clock);
    check("pre_rst_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    Reset = 1'b0;
    @(negedge Clock);
    check("mid_rst_V", 32'(V), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    Reset = 1'b1;
    model_reset();
    @(negedge Clock);
    check("post_rst_V", 32'(V), 32'd1);
    drain_en = 1'b1;
    ev_cnt   = 0;
    repeat (4) frame(16'h8001);
    check("rst_repress_cnt", 32'(ev_cnt), 32'd2);
    repeat (5) frame('0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
